// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked sequential ALU: op codes, FSM states,
// and the legacy op constants from the single-cycle ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_OR   = 4'd0,
      OP_AND  = 4'd1,
      OP_XOR  = 4'd2,
      OP_ADD  = 4'd3,
      OP_NOR  = 4'd4,
      OP_NAND = 4'd5,
      OP_SLT  = 4'd6,
      OP_SUB  = 4'd7,
      OP_SLTS = 4'd8,
      OP_SLL  = 4'd9,
      OP_SRL  = 4'd10,
      OP_SRA  = 4'd11,
      OP_MUL  = 4'd12,
      OP_DIVU = 4'd13,
      OP_REMU = 4'd14,
      OP_RSVD = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Legacy names from the single-cycle datapath
   localparam logic [3:0] ALU_OR   = 4'd0;
   localparam logic [3:0] ALU_AND  = 4'd1;
   localparam logic [3:0] ALU_XOR  = 4'd2;
   localparam logic [3:0] ALU_ADD  = 4'd3;
   localparam logic [3:0] ALU_NOR  = 4'd4;
   localparam logic [3:0] ALU_NAND = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SUB  = 4'd7;

   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_DIV = 1'b1;

   // Ops that need the iterative unit; divide by zero resolves in one step
   function automatic logic is_iter(input op_e op, input logic b_nz);
      return (op == OP_MUL) || (((op == OP_DIVU) || (op == OP_REMU)) && b_nz);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one step per cycle.
// done flags the cycle whose edge completes the last step; prod/quot/rem carry that step's values.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] prod,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] acc_q, sh_q, md_q;
   logic [WIDTH-1:0] acc_d, sh_d, md_d;
   logic [CW-1:0]    cnt_q;
   logic             run_q, mode_q;
   logic [WIDTH:0]   r_sh, r_sub;

   // One step: acc is the product accumulator (mul) or partial remainder (div)
   always_comb begin
      acc_d = acc_q;
      sh_d  = sh_q;
      md_d  = md_q;
      r_sh  = {acc_q, sh_q[WIDTH-1]};
      r_sub = r_sh - {1'b0, md_q};
      if (mode_q == MODE_MUL) begin
         acc_d = acc_q + (sh_q[0] ? md_q : '0);
         md_d  = md_q << 1;
         sh_d  = sh_q >> 1;
      end else if (!r_sub[WIDTH]) begin
         acc_d = r_sub[WIDTH-1:0];
         sh_d  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_d = r_sh[WIDTH-1:0];
         sh_d  = {sh_q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q  <= '0;
         sh_q   <= '0;
         md_q   <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         mode_q <= MODE_MUL;
      end else if (start) begin
         acc_q  <= '0;
         sh_q   <= (mode == MODE_MUL) ? b : a;
         md_q   <= (mode == MODE_MUL) ? a : b;
         cnt_q  <= '0;
         run_q  <= 1'b1;
         mode_q <= mode;
      end else if (run_q) begin
         acc_q <= acc_d;
         sh_q  <= sh_d;
         md_q  <= md_d;
         cnt_q <= cnt_q + CW'(1);
         if (done) run_q <= 1'b0;
      end
   end

   assign done = run_q && (cnt_q == CW'(WIDTH - 1));
   assign prod = acc_d;
   assign quot = sh_d;
   assign rem  = acc_d;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-step datapath plus iterative mul/div behind valid/ready,
// with registered result and flags that update only on entry to DONE.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf,
   output logic             dz
);

   state_e           state_q, state_d;
   op_e              op_i, op_q;
   logic [WIDTH-1:0] sum, diff, res_c, it_res;
   logic [SHW-1:0]   shamt;
   logic             ovf_c, dz_c, accept, start, take_single, take_iter;
   logic             it_done;
   logic [WIDTH-1:0] it_prod, it_quot, it_rem;

   assign op_i  = op_e'(op);
   assign shamt = b[SHW-1:0];

   // Single-step datapath
   always_comb begin
      sum   = a + b;
      diff  = a - b;
      res_c = '0;
      ovf_c = 1'b0;
      dz_c  = 1'b0;
      case (op_i)
         OP_OR:   res_c = a | b;
         OP_AND:  res_c = a & b;
         OP_XOR:  res_c = a ^ b;
         OP_ADD: begin
            res_c = sum;
            ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_NOR:  res_c = ~(a | b);
         OP_NAND: res_c = ~(a & b);
         OP_SLT:  res_c = WIDTH'(a < b);
         OP_SUB: begin
            res_c = diff;
            ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLTS: res_c = WIDTH'($signed(a) < $signed(b));
         OP_SLL:  res_c = a << shamt;
         OP_SRL:  res_c = a >> shamt;
         OP_SRA:  res_c = WIDTH'($signed(a) >>> shamt);
         OP_DIVU: if (b == '0) begin
            res_c = '1;
            dz_c  = 1'b1;
         end
         OP_REMU: if (b == '0) begin
            res_c = a;
            dz_c  = 1'b1;
         end
         default: res_c = '0;
      endcase
   end

   assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign accept   = in_valid && in_ready;

   // Next-state and datapath control
   always_comb begin
      state_d     = state_q;
      start       = 1'b0;
      take_single = 1'b0;
      take_iter   = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               if (is_iter(op_i, b != '0)) begin
                  start   = 1'b1;
                  state_d = S_BUSY;
               end else begin
                  take_single = 1'b1;
                  state_d     = S_DONE;
               end
            end else if ((state_q == S_DONE) && out_ready) begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            if (it_done) begin
               take_iter = 1'b1;
               state_d   = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mode  ((op_i == OP_MUL) ? MODE_MUL : MODE_DIV),
      .a     (a),
      .b     (b),
      .done  (it_done),
      .prod  (it_prod),
      .quot  (it_quot),
      .rem   (it_rem)
   );

   assign it_res = (op_q == OP_MUL)  ? it_prod :
                   (op_q == OP_REMU) ? it_rem  : it_quot;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= OP_OR;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         ovf       <= 1'b0;
         dz        <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_valid <= (state_d == S_DONE);
         if (start) op_q <= op_i;
         if (take_single) begin
            result <= res_c;
            zero   <= (res_c == '0);
            ovf    <= ovf_c;
            dz     <= dz_c;
         end else if (take_iter) begin
            result <= it_res;
            zero   <= (it_res == '0);
            ovf    <= 1'b0;
            dz     <= 1'b0;
         end
      end
   end

endmodule
